// File: rtl/demux_l2.sv
// 1:2 byte demux: rebuilds lane 0 / lane 1 pairs from a serialized clk_4f byte stream, aligned to the first valid byte.
// Pair is registered on the lane 1 edge and held for two clk_4f cycles; no backpressure, consumer samples at clk_2f rate.
module demux_l2 #(
    parameter int DATA_W     = 8,
    parameter int IDLE_LIMIT = 16
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_000,
    input  logic              valid_000,
    output logic [DATA_W-1:0] data_00,
    output logic              valid_00,
    output logic [DATA_W-1:0] data_11,
    output logic              valid_11,
    output logic              locked
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LANE0    = 2'd1,
        LANE1    = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        idle_cnt;
    logic [DATA_W-1:0] hold_dat;
    logic              hold_vld;
    logic              idle_expire;

    // Loss of activity wins over any pair write scheduled on the same edge.
    assign idle_expire = (state != UNLOCKED) && !valid_000 &&
                         (idle_cnt == 8'(IDLE_LIMIT - 1));

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            idle_cnt <= 8'd0;
            hold_dat <= '0;
            hold_vld <= 1'b0;
            data_00  <= '0;
            valid_00 <= 1'b0;
            data_11  <= '0;
            valid_11 <= 1'b0;
        end else if (idle_expire) begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            idle_cnt <= 8'd0;
            hold_vld <= 1'b0;
            valid_00 <= 1'b0;
            valid_11 <= 1'b0;
        end else begin
            case (state)
                UNLOCKED: begin
                    idle_cnt <= 8'd0;
                    if (valid_000) begin
                        hold_dat <= data_000;
                        hold_vld <= 1'b1;
                        state    <= LANE1;
                        locked   <= 1'b1;
                    end
                end
                LANE0: begin
                    idle_cnt <= valid_000 ? 8'd0 : idle_cnt + 8'd1;
                    hold_dat <= data_000;
                    hold_vld <= valid_000;
                    state    <= LANE1;
                end
                LANE1: begin
                    idle_cnt <= valid_000 ? 8'd0 : idle_cnt + 8'd1;
                    // Invalid bytes keep the last good data; only the valid flag drops.
                    valid_00 <= hold_vld;
                    if (hold_vld) data_00 <= hold_dat;
                    valid_11 <= valid_000;
                    if (valid_000) data_11 <= data_000;
                    state    <= LANE0;
                end
                default: begin
                    state    <= UNLOCKED;
                    locked   <= 1'b0;
                    idle_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_l2.sv
// Directed bench for demux_l2: vector table for the streaming cases, hand sequences for idle timeout and async reset.
module tb_demux_l2;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [7:0] data_000;
    logic       valid_000;
    logic [7:0] data_00;
    logic       valid_00;
    logic [7:0] data_11;
    logic       valid_11;
    logic       locked;

    int total = 0;
    int bad   = 0;

    demux_l2 #(.DATA_W(8), .IDLE_LIMIT(16)) dut (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .data_000 (data_000),
        .valid_000(valid_000),
        .data_00  (data_00),
        .valid_00 (valid_00),
        .data_11  (data_11),
        .valid_11 (valid_11),
        .locked   (locked)
    );

    always #5 clk_4f = ~clk_4f;

    // Packed view: {locked, valid_00, data_00, valid_11, data_11}
    function automatic logic [18:0] ex(input logic l, input logic v0, input logic [7:0] d0,
                                       input logic v1, input logic [7:0] d1);
        return {l, v0, d0, v1, d1};
    endfunction

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [18:0] want);
        logic [18:0] got;
        got = {locked, valid_00, data_00, valid_11, data_11};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got lk=%b v00=%b d00=%h v11=%b d11=%h, want lk=%b v00=%b d00=%h v11=%b d11=%h",
                     name, got[18], got[17], got[16:9], got[8], got[7:0],
                     want[18], want[17], want[16:9], want[8], want[7:0]);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        valid_000 = v;
        data_000  = d;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic do_reset();
        valid_000 = 1'b0;
        data_000  = 8'h00;
        reset     = 1'b1;
        repeat (3) @(posedge clk_4f);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Streaming, hole in lane 1, counter clear on valid
        vecs[0]  = '{1'b1, 8'hA1, ex(1, 0, 8'h00, 0, 8'h00)};
        vecs[1]  = '{1'b1, 8'hB2, ex(1, 1, 8'hA1, 1, 8'hB2)};
        vecs[2]  = '{1'b1, 8'hC3, ex(1, 1, 8'hA1, 1, 8'hB2)};
        vecs[3]  = '{1'b1, 8'hD4, ex(1, 1, 8'hC3, 1, 8'hD4)};
        vecs[4]  = '{1'b1, 8'h33, ex(1, 1, 8'hC3, 1, 8'hD4)};
        vecs[5]  = '{1'b0, 8'hFF, ex(1, 1, 8'h33, 0, 8'hD4)};
        vecs[6]  = '{1'b1, 8'h44, ex(1, 1, 8'h33, 0, 8'hD4)};
        vecs[7]  = '{1'b1, 8'h55, ex(1, 1, 8'h44, 1, 8'h55)};
        // Invalid lane 0 byte keeps phase: lane 1 still lands in data_11
        vecs[8]  = '{1'b0, 8'hEE, ex(1, 1, 8'h44, 1, 8'h55)};
        vecs[9]  = '{1'b1, 8'h66, ex(1, 0, 8'h44, 1, 8'h66)};
        vecs[10] = '{1'b1, 8'h12, ex(1, 0, 8'h44, 1, 8'h66)};
        vecs[11] = '{1'b1, 8'h34, ex(1, 1, 8'h12, 1, 8'h34)};
        vecs[12] = '{1'b1, 8'h44, ex(1, 1, 8'h12, 1, 8'h34)};
        vecs[13] = '{1'b1, 8'h55, ex(1, 1, 8'h44, 1, 8'h55)};
        vecs[14] = '{1'b1, 8'h44, ex(1, 1, 8'h44, 1, 8'h55)};
        vecs[15] = '{1'b1, 8'h55, ex(1, 1, 8'h44, 1, 8'h55)};

        reset     = 1'b1;
        valid_000 = 1'b0;
        data_000  = 8'h00;
        #1;
        check("reset_async_state", ex(0, 0, 8'h00, 0, 8'h00));
        do_reset();
        check("reset_state", ex(0, 0, 8'h00, 0, 8'h00));

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].d);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Idle timeout: 16 idle edges starting from LANE0 phase
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 8'h99);
            if (k < 16)
                check($sformatf("idle%0d", k), ex(1, k == 1, 8'h44, k == 1, 8'h55));
            else
                check("idle_timeout", ex(0, 0, 8'h44, 0, 8'h55));
        end
        step(1'b1, 8'h5A);
        check("realign_l0", ex(1, 0, 8'h44, 0, 8'h55));
        step(1'b1, 8'h6B);
        check("realign_pair", ex(1, 1, 8'h5A, 1, 8'h6B));

        // One short of the limit: phase is unbroken, next byte is lane 1
        for (int k = 1; k <= 15; k++) step(1'b0, 8'h00);
        check("idle15_locked", ex(1, 0, 8'h5A, 0, 8'h6B));
        step(1'b1, 8'h77);
        check("idle15_lane1", ex(1, 0, 8'h5A, 1, 8'h77));
        step(1'b1, 8'h88);
        step(1'b1, 8'h99);
        check("idle15_pair", ex(1, 1, 8'h88, 1, 8'h99));

        // Late alignment
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 8'hC0);
            check($sformatf("late_idle%0d", k), ex(0, 0, 8'h00, 0, 8'h00));
        end
        step(1'b1, 8'h11);
        check("late_l0", ex(1, 0, 8'h00, 0, 8'h00));
        step(1'b1, 8'h22);
        check("late_pair", ex(1, 1, 8'h11, 1, 8'h22));

        // Async reset between lane 0 and lane 1 edges
        step(1'b1, 8'hAB);
        #2;
        reset = 1'b1;
        #1;
        check("arst_immediate", ex(0, 0, 8'h00, 0, 8'h00));
        valid_000 = 1'b1;
        data_000  = 8'hBC;
        @(posedge clk_4f);
        #1;
        check("arst_held", ex(0, 0, 8'h00, 0, 8'h00));
        reset = 1'b0;
        step(1'b1, 8'hCD);
        check("arst_l0", ex(1, 0, 8'h00, 0, 8'h00));
        step(1'b1, 8'hEF);
        check("arst_pair", ex(1, 1, 8'hCD, 1, 8'hEF));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
